// File: rtl/fft64_share_ctl.sv
// Frame-granular round-robin sharing of one fft64 core between a forward (port 0)
// and an inverse (port 1, re/im swapped) requester, with in-order output steering.
module fft64_share_ctl #(
    parameter int width  = 11,
    parameter int FRAMES = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req0,
    input  logic             req1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rdy0,
    output logic             rdy1,
    input  logic             valid0,
    input  logic             valid1,
    input  logic [width-1:0] ar0,
    input  logic [width-1:0] ai0,
    input  logic [width-1:0] ar1,
    input  logic [width-1:0] ai1,
    output logic             core_valid_a,
    output logic [width-1:0] core_ar,
    output logic [width-1:0] core_ai,
    input  logic             core_full,
    input  logic             core_valid_o,
    input  logic [width-1:0] core_xr,
    input  logic [width-1:0] core_xi,
    output logic             core_rd_en,
    output logic             out_valid0,
    output logic             out_valid1,
    output logic [width-1:0] xr0,
    output logic [width-1:0] xi0,
    output logic [width-1:0] xr1,
    output logic [width-1:0] xi1,
    input  logic             rd_en0,
    input  logic             rd_en1
);

    localparam int AW = $clog2(FRAMES);
    localparam logic [AW:0] TAG_FULL = (AW + 1)'(FRAMES);

    typedef enum logic [1:0] {IDLE, FEED0, FEED1} state_t;

    state_t            state, state_nx;
    logic              last;
    logic [5:0]        in_cnt, out_cnt;
    logic [FRAMES-1:0] tag_mem;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       tag_cnt;

    logic tag_empty, tag_full, head, tag_push, tag_pop, push_id, accept;

    assign tag_empty = (tag_cnt == '0);
    assign tag_full  = (tag_cnt == TAG_FULL);
    assign head      = tag_mem[rd_ptr];

    assign gnt0   = (state == FEED0);
    assign gnt1   = (state == FEED1);
    assign rdy0   = gnt0 & ~core_full;
    assign rdy1   = gnt1 & ~core_full;
    assign accept = (valid0 & rdy0) | (valid1 & rdy1);

    // Output steering is purely combinational from the core and the head tag.
    assign out_valid0 = core_valid_o & ~tag_empty & ~head;
    assign out_valid1 = core_valid_o & ~tag_empty & head;
    assign core_rd_en = (out_valid0 & rd_en0) | (out_valid1 & rd_en1);
    assign tag_pop    = core_rd_en & (out_cnt == 6'd63);

    assign xr0 = out_valid0 ? core_xr : '0;
    assign xi0 = out_valid0 ? core_xi : '0;
    assign xr1 = out_valid1 ? core_xi : '0;
    assign xi1 = out_valid1 ? core_xr : '0;

    always_comb begin
        state_nx = state;
        tag_push = 1'b0;
        push_id  = 1'b0;
        case (state)
            IDLE: begin
                // A tag popping this cycle frees its slot for the new grant.
                if ((~tag_full | tag_pop) && (req0 | req1)) begin
                    push_id  = (req0 & req1) ? ~last : req1;
                    tag_push = 1'b1;
                    state_nx = push_id ? FEED1 : FEED0;
                end
            end
            FEED0: if (valid0 && rdy0 && in_cnt == 6'd63) state_nx = IDLE;
            FEED1: if (valid1 && rdy1 && in_cnt == 6'd63) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        core_valid_a = 1'b0;
        core_ar      = '0;
        core_ai      = '0;
        case (state)
            FEED0: begin
                core_valid_a = valid0 & rdy0;
                core_ar      = ar0;
                core_ai      = ai0;
            end
            FEED1: begin
                core_valid_a = valid1 & rdy1;
                core_ar      = ai1;
                core_ai      = ar1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            last    <= 1'b1;
            in_cnt  <= '0;
            out_cnt <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tag_cnt <= '0;
        end else begin
            state <= state_nx;
            if (tag_push) begin
                tag_mem[wr_ptr] <= push_id;
                wr_ptr          <= wr_ptr + AW'(1);
                last            <= push_id;
                in_cnt          <= '0;
            end else if (accept) begin
                in_cnt <= in_cnt + 6'd1;
            end
            if (core_rd_en) out_cnt <= out_cnt + 6'd1;
            if (tag_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({tag_push, tag_pop})
                2'b10:   tag_cnt <= tag_cnt + (AW + 1)'(1);
                2'b01:   tag_cnt <= tag_cnt - (AW + 1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fft64_share_ctl.sv
// Scoreboard bench for fft64_share_ctl with a stand-in FIFO core (xr=in_r+3, xi=in_i^0x55).
module tb_fft64_share_ctl;

    localparam int W = 11;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic req_s [2];
    logic valid_s [2];
    logic [W-1:0] ar_s [2];
    logic [W-1:0] ai_s [2];
    logic rd_en0 = 1'b0, rd_en1 = 1'b0;
    logic gnt0, gnt1, rdy0, rdy1, core_valid_a, core_full, core_valid_o, core_rd_en;
    logic out_valid0, out_valid1;
    logic [W-1:0] core_ar, core_ai, core_xr, core_xi, xr0, xi0, xr1, xi1;

    always #5 CLK = ~CLK;

    fft64_share_ctl #(.width(W), .FRAMES(4)) dut (
        .CLK(CLK), .RST(RST),
        .req0(req_s[0]), .req1(req_s[1]), .gnt0(gnt0), .gnt1(gnt1),
        .rdy0(rdy0), .rdy1(rdy1), .valid0(valid_s[0]), .valid1(valid_s[1]),
        .ar0(ar_s[0]), .ai0(ai_s[0]), .ar1(ar_s[1]), .ai1(ai_s[1]),
        .core_valid_a(core_valid_a), .core_ar(core_ar), .core_ai(core_ai),
        .core_full(core_full), .core_valid_o(core_valid_o),
        .core_xr(core_xr), .core_xi(core_xi), .core_rd_en(core_rd_en),
        .out_valid0(out_valid0), .out_valid1(out_valid1),
        .xr0(xr0), .xi0(xi0), .xr1(xr1), .xi1(xi1),
        .rd_en0(rd_en0), .rd_en1(rd_en1)
    );

    // Stand-in core: a deep FIFO applying a simple, known per-word transform.
    logic [2*W-1:0] cmem [1024];
    logic [15:0] cwp = '0, crp = '0, cocc;
    logic [2*W-1:0] chead;
    logic force_full = 1'b0;
    assign cocc = cwp - crp;
    assign chead = cmem[crp[9:0]];
    assign core_valid_o = (cocc != 16'd0);
    assign core_xr = chead[2*W-1:W] + W'(3);
    assign core_xi = chead[W-1:0] ^ W'(8'h55);
    assign core_full = force_full | (cocc >= 16'd300);

    always @(posedge CLK) begin
        if (RST) begin
            cwp <= '0;
            crp <= '0;
        end else begin
            if (core_valid_a) begin
                cmem[cwp[9:0]] <= {core_ar, core_ai};
                cwp <= cwp + 16'd1;
            end
            if (core_rd_en) crp <= crp + 16'd1;
        end
    end

    int n_vec = 0, n_err = 0;
    int grants = 0, in_words = 0, model_last = 1;
    int pidx [2];
    bit abort = 0, cons_en = 1, pg0 = 0, pg1 = 0;
    logic [2*W-1:0] q_in0 [$];
    logic [2*W-1:0] q_in1 [$];
    int own_q [$];
    logic [2*W:0] exp_out [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference round-robin: both requesters present at each decision, alternate away from last.
    task automatic rr_push(input int n0, input int n1);
        int pick;
        while (n0 > 0 || n1 > 0) begin
            if (n0 > 0 && n1 > 0) pick = (model_last == 0) ? 1 : 0;
            else pick = (n0 > 0) ? 0 : 1;
            own_q.push_back(pick);
            model_last = pick;
            if (pick == 0) n0--; else n1--;
        end
    endtask

    always begin
        @(posedge CLK);
        #1;
        rd_en0 = cons_en && ($urandom_range(3) != 0);
        rd_en1 = cons_en && ($urandom_range(3) != 0);
    end

    always @(negedge CLK) begin
        logic [2*W:0] e;
        logic [2*W-1:0] s;
        logic [W-1:0] sr, si;
        logic ep, fire;
        int o;
        if (!RST) begin
            if (core_valid_o) begin
                chk("model_has_word", 32'(exp_out.size() != 0), 1);
                if (exp_out.size() != 0) begin
                    e = exp_out[0];
                    ep = e[2*W];
                    chk("out_valid0", out_valid0, !ep);
                    chk("out_valid1", out_valid1, ep);
                    fire = ep ? rd_en1 : rd_en0;
                    chk("core_rd_en", core_rd_en, fire);
                    if (fire) begin
                        chk("xr", ep ? xr1 : xr0, e[2*W-1:W]);
                        chk("xi", ep ? xi1 : xi0, e[W-1:0]);
                        void'(exp_out.pop_front());
                    end
                end
            end else begin
                chk("out_valid_idle", {out_valid0, out_valid1}, 0);
                chk("core_rd_en_idle", core_rd_en, 0);
            end

            if (core_full) chk("accept_while_full", {rdy0, rdy1, core_valid_a}, 0);
            chk("gnt_exclusive", gnt0 & gnt1, 0);
            if (pg0) chk("bubble_after_0", gnt1, 0);
            if (pg1) chk("bubble_after_1", gnt0, 0);
            if ((gnt0 && !pg0) || (gnt1 && !pg1)) grants++;
            pg0 = gnt0;
            pg1 = gnt1;

            if (core_valid_a) begin
                chk("owner_known", 32'(own_q.size() != 0), 1);
                if (own_q.size() != 0) begin
                    o = own_q[0];
                    chk("gnt_owner", o ? gnt1 : gnt0, 1);
                    chk("sample_known", 32'(o ? q_in1.size() != 0 : q_in0.size() != 0), 1);
                    s = o ? q_in1.pop_front() : q_in0.pop_front();
                    sr = s[2*W-1:W];
                    si = s[W-1:0];
                    chk("core_ar", core_ar, o ? si : sr);
                    chk("core_ai", core_ai, o ? sr : si);
                    if (o != 0) exp_out.push_back({1'b1, sr ^ W'(8'h55), si + W'(3)});
                    else exp_out.push_back({1'b0, sr + W'(3), si ^ W'(8'h55)});
                    in_words++;
                    if (in_words == 64) begin
                        in_words = 0;
                        void'(own_q.pop_front());
                    end
                end
            end
        end
    end

    // mode 0: random samples; 1: ar=n, ai=0; 2: ar=n, ai=7
    task automatic drive_port(input int p, input int nfr, input int vpct, input int mode);
        logic [2*W-1:0] fr [64];
        logic [W-1:0] r, i;
        int idx, cyc;
        bit got;
        @(posedge CLK);
        #1;
        for (int f = 0; f < nfr; f++) begin
            for (int n = 0; n < 64; n++) begin
                r = (mode == 0) ? W'($urandom) : W'(n);
                i = (mode == 0) ? W'($urandom) : (mode == 2) ? W'(7) : '0;
                fr[n] = {r, i};
                if (p != 0) q_in1.push_back({r, i}); else q_in0.push_back({r, i});
            end
            req_s[p] = 1'b1;
            got = 0;
            for (int t = 0; t < 3000 && !got && !abort; t++) begin
                @(negedge CLK);
                got = (p != 0) ? gnt1 : gnt0;
            end
            if (abort) begin
                req_s[p] = 1'b0;
                return;
            end
            chk($sformatf("grant_seen_p%0d", p), 32'(got), 1);
            if (!got) begin
                req_s[p] = 1'b0;
                return;
            end
            idx = 0;
            cyc = 0;
            pidx[p] = 0;
            while (idx < 64 && cyc < 2000) begin
                @(posedge CLK);
                #1;
                if (abort) begin
                    valid_s[p] = 1'b0;
                    req_s[p] = 1'b0;
                    return;
                end
                valid_s[p] = ($urandom_range(99) < vpct);
                ar_s[p] = fr[idx][2*W-1:W];
                ai_s[p] = fr[idx][W-1:0];
                @(negedge CLK);
                if (valid_s[p] && ((p != 0) ? rdy1 : rdy0)) begin
                    idx++;
                    pidx[p] = idx;
                end
                cyc++;
            end
            chk($sformatf("frame_accepts_p%0d", p), idx, 64);
            @(posedge CLK);
            #1;
            valid_s[p] = 1'b0;
            if (f == nfr - 1) req_s[p] = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_out.size() != 0 || own_q.size() != 0) && t < 5000) begin
            @(negedge CLK);
            t++;
        end
        chk("drain_words_left", exp_out.size(), 0);
        chk("drain_frames_left", own_q.size(), 0);
        repeat (3) @(posedge CLK);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"}, {gnt0, gnt1, rdy0, rdy1}, 0);
        chk({tag, "_core_in"}, {core_valid_a, core_ar, core_ai}, 0);
        chk({tag, "_core_rd_en"}, core_rd_en, 0);
        chk({tag, "_out_valid"}, {out_valid0, out_valid1}, 0);
        chk({tag, "_out_data0"}, {xr0, xi0}, 0);
        chk({tag, "_out_data1"}, {xr1, xi1}, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        for (int p = 0; p < 2; p++) begin
            req_s[p] = 1'b0;
            valid_s[p] = 1'b0;
            ar_s[p] = '0;
            ai_s[p] = '0;
            pidx[p] = 0;
        end
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_all_zero("reset");
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Port 0 alone, ar0=n, ai0=0, plus grant latency
        rr_push(1, 0);
        fork
            drive_port(0, 1, 100, 1);
            begin
                t = 0;
                while (!req_s[0] && t < 20) begin
                    @(negedge CLK);
                    t++;
                end
                chk("gnt0_same_cycle", gnt0, 0);
                @(negedge CLK);
                chk("gnt0_latency", gnt0, 1);
            end
        join
        drain();

        // Port 1 alone, ar1=n, ai1=7 (swap)
        rr_push(0, 1);
        drive_port(1, 1, 100, 2);
        drain();

        // Both held: grant order alternates 0,1,0,1
        rr_push(2, 2);
        fork
            drive_port(0, 2, 70, 0);
            drive_port(1, 2, 70, 0);
        join
        drain();

        // core_full held for 10 cycles mid-frame
        rr_push(1, 0);
        fork
            drive_port(0, 1, 100, 0);
            begin
                t = 0;
                while (!gnt0 && t < 100) begin
                    @(negedge CLK);
                    t++;
                end
                repeat (10) @(posedge CLK);
                #1;
                force_full = 1'b1;
                repeat (10) @(posedge CLK);
                #1;
                force_full = 1'b0;
            end
        join
        drain();

        // Consumers stalled: only FRAMES grants until a frame is popped
        grants = 0;
        rr_push(5, 0);
        fork
            drive_port(0, 5, 100, 0);
            begin
                cons_en = 0;
                repeat (600) @(posedge CLK);
                @(negedge CLK);
                chk("grants_while_stalled", grants, 4);
                repeat (50) begin
                    @(negedge CLK);
                    chk("gnt0_held_off", gnt0, 0);
                end
                cons_en = 1;
            end
        join
        drain();
        chk("grants_after_release", grants, 5);

        // Mixed traffic
        rr_push(2, 1);
        fork
            drive_port(0, 2, 80, 0);
            drive_port(1, 1, 80, 0);
        join
        drain();

        // Reset in the middle of a port 1 frame
        pidx[1] = 0;
        rr_push(0, 1);
        fork
            drive_port(1, 1, 100, 0);
            begin
                t = 0;
                while (pidx[1] < 30 && t < 500) begin
                    @(negedge CLK);
                    t++;
                end
                chk("reached_sample_30", 32'(pidx[1] >= 30), 1);
                @(posedge CLK);
                #1;
                RST = 1'b1;
                abort = 1;
                q_in0.delete();
                q_in1.delete();
                own_q.delete();
                exp_out.delete();
                in_words = 0;
                pg0 = 0;
                pg1 = 0;
            end
        join
        req_s[0] = 1'b0;
        req_s[1] = 1'b0;
        valid_s[0] = 1'b0;
        valid_s[1] = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check_all_zero("mid_reset");
        @(posedge CLK);
        #1;
        RST = 1'b0;
        abort = 0;
        model_last = 1;
        rr_push(1, 1);
        fork
            drive_port(0, 1, 90, 0);
            drive_port(1, 1, 90, 0);
        join
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
